// File: rtl/operand_bypass_unit.sv
// Execute-stage operand bypass: captures decode operands, forwards from the M/W
// producers, detects load-use hazards and counts the stall cycles they cost.
module operand_bypass_unit #(
    parameter int DATA_BITS = 32,
    parameter int REG_BITS  = 5,
    parameter int NUM_SRC   = 2,
    parameter int CNT_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          d_valid,
    input  logic [NUM_SRC*REG_BITS-1:0]   d_src_reg,
    input  logic [NUM_SRC*DATA_BITS-1:0]  d_src_data,
    output logic                          d_ready,
    input  logic                          e_hold,
    input  logic                          flush,
    input  logic                          e_is_load,
    input  logic                          e_reg_write,
    input  logic [REG_BITS-1:0]           e_dst_reg,
    input  logic                          m_reg_write,
    input  logic [REG_BITS-1:0]           m_dst_reg,
    input  logic [DATA_BITS-1:0]          alu_out_m,
    input  logic                          w_reg_write,
    input  logic [REG_BITS-1:0]           w_dst_reg,
    input  logic [DATA_BITS-1:0]          result_w,
    output logic                          e_valid,
    output logic [NUM_SRC*2-1:0]          e_fwd_sel,
    output logic [NUM_SRC*DATA_BITS-1:0]  src_e,
    output logic                          load_use_stall,
    output logic [CNT_BITS-1:0]           stall_cycles
);

    logic                 e_valid_reg;
    logic                 e_valid_next;
    logic [CNT_BITS-1:0]  stall_cnt_reg;
    logic [NUM_SRC-1:0]   dep_hit;
    logic                 hold;
    logic                 accept;

    assign hold   = e_valid_reg && e_hold && !flush;
    assign accept = d_valid && d_ready && !flush;

    assign load_use_stall = d_valid && e_valid_reg && e_is_load && e_reg_write &&
                            (e_dst_reg != '0) && (|dep_hit);
    assign d_ready        = !load_use_stall && !(e_valid_reg && e_hold);
    assign e_valid        = e_valid_reg;
    assign stall_cycles   = stall_cnt_reg;

    always_comb begin
        e_valid_next = 1'b0;
        if (flush)
            e_valid_next = 1'b0;
        else if (hold || accept)
            e_valid_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            e_valid_reg <= e_valid_next;
            if (load_use_stall && (stall_cnt_reg != {CNT_BITS{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_BITS'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_BITS-1:0]  e_src_reg;
            logic [REG_BITS-1:0]  e_src_next;
            logic [DATA_BITS-1:0] cap_reg;
            logic [DATA_BITS-1:0] cap_next;
            logic [REG_BITS-1:0]  d_reg;
            logic [DATA_BITS-1:0] d_data;
            logic                 m_hit;
            logic                 w_hit;
            logic                 d_w_hit;
            logic [DATA_BITS-1:0] fwd_val;

            assign d_reg  = d_src_reg[gi*REG_BITS +: REG_BITS];
            assign d_data = d_src_data[gi*DATA_BITS +: DATA_BITS];

            // Register 0 is hard-wired zero, so it never matches a producer.
            assign m_hit   = e_valid_reg && m_reg_write && (m_dst_reg == e_src_reg) && (e_src_reg != '0);
            assign w_hit   = e_valid_reg && w_reg_write && (w_dst_reg == e_src_reg) && (e_src_reg != '0);
            assign d_w_hit = w_reg_write && (w_dst_reg == d_reg) && (d_reg != '0);

            assign fwd_val = m_hit ? alu_out_m : (w_hit ? result_w : cap_reg);
            assign src_e[gi*DATA_BITS +: DATA_BITS] = fwd_val;
            assign e_fwd_sel[gi*2 +: 2] = m_hit ? 2'b10 : (w_hit ? 2'b01 : 2'b00);
            assign dep_hit[gi] = (d_reg == e_dst_reg);

            // During a hold the forwarded value is re-captured so a producer
            // that retires while we wait is not lost.
            always_comb begin
                cap_next   = cap_reg;
                e_src_next = e_src_reg;
                if (flush) begin
                    cap_next   = cap_reg;
                end else if (hold) begin
                    cap_next   = fwd_val;
                end else if (accept) begin
                    e_src_next = d_reg;
                    cap_next   = d_w_hit ? result_w : d_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    e_src_reg <= '0;
                    cap_reg   <= '0;
                end else begin
                    e_src_reg <= e_src_next;
                    cap_reg   <= cap_next;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic, all
// compared every cycle against a transaction-level model of the execute slot.
module tb_operand_bypass_unit;

    localparam int DB = 32;
    localparam int RB = 5;
    localparam int NS = 2;
    localparam int CB = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              d_valid;
    logic [NS*RB-1:0]  d_src_reg;
    logic [NS*DB-1:0]  d_src_data;
    logic              d_ready;
    logic              e_hold, flush, e_is_load, e_reg_write;
    logic [RB-1:0]     e_dst_reg;
    logic              m_reg_write;
    logic [RB-1:0]     m_dst_reg;
    logic [DB-1:0]     alu_out_m;
    logic              w_reg_write;
    logic [RB-1:0]     w_dst_reg;
    logic [DB-1:0]     result_w;
    logic              e_valid;
    logic [NS*2-1:0]   e_fwd_sel;
    logic [NS*DB-1:0]  src_e;
    logic              load_use_stall;
    logic [CB-1:0]     stall_cycles;

    logic              d_ready2, e_valid2, load_use_stall2;
    logic [NS*2-1:0]   e_fwd_sel2;
    logic [NS*DB-1:0]  src_e2;
    logic [1:0]        stall_cycles2;

    always #5 clk = ~clk;

    operand_bypass_unit #(.DATA_BITS(DB), .REG_BITS(RB), .NUM_SRC(NS), .CNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_src_reg(d_src_reg),
        .d_src_data(d_src_data), .d_ready(d_ready), .e_hold(e_hold), .flush(flush),
        .e_is_load(e_is_load), .e_reg_write(e_reg_write), .e_dst_reg(e_dst_reg),
        .m_reg_write(m_reg_write), .m_dst_reg(m_dst_reg), .alu_out_m(alu_out_m),
        .w_reg_write(w_reg_write), .w_dst_reg(w_dst_reg), .result_w(result_w),
        .e_valid(e_valid), .e_fwd_sel(e_fwd_sel), .src_e(src_e),
        .load_use_stall(load_use_stall), .stall_cycles(stall_cycles)
    );

    operand_bypass_unit #(.DATA_BITS(DB), .REG_BITS(RB), .NUM_SRC(NS), .CNT_BITS(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_src_reg(d_src_reg),
        .d_src_data(d_src_data), .d_ready(d_ready2), .e_hold(e_hold), .flush(flush),
        .e_is_load(e_is_load), .e_reg_write(e_reg_write), .e_dst_reg(e_dst_reg),
        .m_reg_write(m_reg_write), .m_dst_reg(m_dst_reg), .alu_out_m(alu_out_m),
        .w_reg_write(w_reg_write), .w_dst_reg(w_dst_reg), .result_w(result_w),
        .e_valid(e_valid2), .e_fwd_sel(e_fwd_sel2), .src_e(src_e2),
        .load_use_stall(load_use_stall2), .stall_cycles(stall_cycles2)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Model of the execute slot: one instruction with its source numbers and
    // the operand values it has gathered so far; plus a plain stall tally.
    bit            slot_live;
    int unsigned   slot_src [NS];
    logic [DB-1:0] slot_val [NS];
    int unsigned   stall_tally;

    task automatic chk(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic void model_reset();
        slot_live = 0;
        stall_tally = 0;
        for (int i = 0; i < NS; i++) begin
            slot_src[i] = 0;
            slot_val[i] = '0;
        end
    endfunction

    // Youngest in-flight producer of register r: 2 = memory stage, 1 = writeback.
    function automatic int producer(input int unsigned r, output logic [DB-1:0] v);
        v = '0;
        if (r == 0) return 0;
        if (m_reg_write && m_dst_reg == r) begin v = alu_out_m; return 2; end
        if (w_reg_write && w_dst_reg == r) begin v = result_w; return 1; end
        return 0;
    endfunction

    task automatic idle();
        d_valid = 0; d_src_reg = '0; d_src_data = '0; e_hold = 0; flush = 0;
        e_is_load = 0; e_reg_write = 0; e_dst_reg = '0;
        m_reg_write = 0; m_dst_reg = '0; alu_out_m = '0;
        w_reg_write = 0; w_dst_reg = '0; result_w = '0;
    endtask

    task automatic set_src(input int i, input int r, input logic [DB-1:0] v);
        d_src_reg[i*RB +: RB]  = RB'(r);
        d_src_data[i*DB +: DB] = v;
    endtask

    // Compare all outputs against the model mid-cycle, then advance the model.
    task automatic step();
        logic [DB-1:0] op_val [NS];
        logic [DB-1:0] pv;
        int            kind;
        bit            exp_stall, exp_ready, dep;
        int unsigned   sat16, sat2;
        @(negedge clk);
        if (!rst_n) model_reset();
        dep = 0;
        for (int i = 0; i < NS; i++)
            if (d_src_reg[i*RB +: RB] == e_dst_reg) dep = 1;
        exp_stall = d_valid && slot_live && e_is_load && e_reg_write && e_dst_reg != 0 && dep;
        exp_ready = !exp_stall && !(slot_live && e_hold);
        chk("e_valid", 32'(e_valid), 32'(slot_live));
        chk("load_use_stall", 32'(load_use_stall), 32'(exp_stall));
        chk("d_ready", 32'(d_ready), 32'(exp_ready));
        for (int i = 0; i < NS; i++) begin
            kind = slot_live ? producer(slot_src[i], pv) : 0;
            op_val[i] = (kind != 0) ? pv : slot_val[i];
            chk($sformatf("sel%0d", i), 32'(e_fwd_sel[i*2 +: 2]), 32'(kind));
            chk($sformatf("src_e%0d", i), src_e[i*DB +: DB], op_val[i]);
        end
        sat16 = (stall_tally > 65535) ? 65535 : stall_tally;
        sat2  = (stall_tally > 3) ? 3 : stall_tally;
        chk("stall_cycles", 32'(stall_cycles), sat16);
        chk("stall_cycles_cnt2", 32'(stall_cycles2), sat2);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (exp_stall) stall_tally++;
            if (flush) begin
                slot_live = 0;
            end else if (slot_live && e_hold) begin
                for (int i = 0; i < NS; i++) slot_val[i] = op_val[i];
            end else if (d_valid && exp_ready) begin
                slot_live = 1;
                for (int i = 0; i < NS; i++) begin
                    slot_src[i] = d_src_reg[i*RB +: RB];
                    if (w_reg_write && slot_src[i] != 0 && w_dst_reg == slot_src[i])
                        slot_val[i] = result_w;
                    else
                        slot_val[i] = d_src_data[i*DB +: DB];
                end
            end else begin
                slot_live = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        step();
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 0;
        #1;
        chk("reset_e_valid", 32'(e_valid), 32'h0);
        chk("reset_stall_cycles", 32'(stall_cycles), 32'h0);
        chk("reset_src_e0", src_e[0 +: DB], 32'h0);
        step();
        rst_n = 1;

        // Memory-stage forward after capture.
        d_valid = 1; set_src(0, 1, 32'h11); set_src(1, 2, 32'h22);
        step();
        idle(); m_reg_write = 1; m_dst_reg = 1; alu_out_m = 32'hAA;
        #1;
        chk("m_fwd_sel0", 32'(e_fwd_sel[1:0]), 32'h2);
        chk("m_fwd_src0", src_e[0 +: DB], 32'hAA);
        chk("m_fwd_src1", src_e[DB +: DB], 32'h22);
        step();

        // M beats W; r0 never forwards.
        idle(); d_valid = 1; set_src(0, 3, 32'h33); set_src(1, 0, 32'h44);
        step();
        idle(); m_reg_write = 1; m_dst_reg = 3; alu_out_m = 32'h5;
        w_reg_write = 1; w_dst_reg = 3; result_w = 32'h6;
        #1;
        chk("prio_src0", src_e[0 +: DB], 32'h5);
        chk("prio_sel0", 32'(e_fwd_sel[1:0]), 32'h2);
        m_dst_reg = 0; w_dst_reg = 0;
        #1;
        chk("r0_sel1", 32'(e_fwd_sel[3:2]), 32'h0);
        chk("r0_src1", src_e[DB +: DB], 32'h44);
        step();

        // Load-use: one stall, one bubble, then the load forwards via W.
        do_reset();
        idle(); d_valid = 1; set_src(0, 5, 32'h5); set_src(1, 6, 32'h6);
        step();
        e_is_load = 1; e_reg_write = 1; e_dst_reg = 4;
        set_src(0, 4, 32'hDEAD); set_src(1, 2, 32'h2);
        #1;
        chk("lu_stall", 32'(load_use_stall), 32'h1);
        chk("lu_ready", 32'(d_ready), 32'h0);
        step();
        e_is_load = 0; m_reg_write = 1; m_dst_reg = 4; alu_out_m = 32'h4444;
        #1;
        chk("lu_bubble", 32'(e_valid), 32'h0);
        chk("lu_count", 32'(stall_cycles), 32'h1);
        chk("lu_reaccept_ready", 32'(d_ready), 32'h1);
        step();
        idle(); w_reg_write = 1; w_dst_reg = 4; result_w = 32'h1234;
        #1;
        chk("lu_w_sel0", 32'(e_fwd_sel[1:0]), 32'h1);
        chk("lu_w_src0", src_e[0 +: DB], 32'h1234);
        step();

        // Hold while the producer moves M -> W -> retired.
        idle(); d_valid = 1; set_src(0, 7, 32'h70); set_src(1, 1, 32'h1);
        step();
        idle(); e_hold = 1; m_reg_write = 1; m_dst_reg = 7; alu_out_m = 32'h77;
        #1;
        chk("hold1_src0", src_e[0 +: DB], 32'h77);
        chk("hold1_ready", 32'(d_ready), 32'h0);
        step();
        m_reg_write = 0; w_reg_write = 1; w_dst_reg = 7; result_w = 32'h77;
        #1;
        chk("hold2_sel0", 32'(e_fwd_sel[1:0]), 32'h1);
        step();
        w_reg_write = 0;
        #1;
        chk("hold3_src0", src_e[0 +: DB], 32'h77);
        chk("hold3_sel0", 32'(e_fwd_sel[1:0]), 32'h0);
        step();

        // Flush beats accept; async reset mid-hold.
        idle(); d_valid = 1; set_src(0, 1, 32'h1); set_src(1, 2, 32'h2);
        step();
        flush = 1;
        step();
        chk("flush_e_valid", 32'(e_valid), 32'h0);
        flush = 0;
        step();
        e_is_load = 1; e_reg_write = 1; e_dst_reg = 4; set_src(0, 4, 32'h9);
        step();
        idle(); d_valid = 1; set_src(0, 1, 32'h1);
        step();
        idle(); e_hold = 1;
        step();
        rst_n = 0;
        #1;
        chk("arst_e_valid", 32'(e_valid), 32'h0);
        chk("arst_stall_cycles", 32'(stall_cycles), 32'h0);
        step();
        rst_n = 1; d_valid = 1; set_src(0, 2, 32'h2);
        #1;
        chk("rel_ready_empty_hold", 32'(d_ready), 32'h1);
        step();
        chk("rel_accept", 32'(e_valid), 32'h1);

        // Five stalls saturate a 2-bit counter at 3.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle(); d_valid = 1; set_src(0, 1, 32'h1); set_src(1, 2, 32'h2);
            step();
            e_is_load = 1; e_reg_write = 1; e_dst_reg = 4; set_src(0, 4, 32'h4);
            step();
        end
        chk("sat_cnt2", 32'(stall_cycles2), 32'h3);
        chk("sat_cnt16", 32'(stall_cycles), 32'h5);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            d_valid     = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NS; i++) set_src(i, $urandom_range(0, 7), $urandom);
            e_hold      = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            e_is_load   = $urandom_range(0, 1);
            e_reg_write = ($urandom_range(0, 3) != 0);
            e_dst_reg   = RB'($urandom_range(0, 7));
            m_reg_write = $urandom_range(0, 1);
            m_dst_reg   = RB'($urandom_range(0, 7));
            alu_out_m   = $urandom;
            w_reg_write = $urandom_range(0, 1);
            w_dst_reg   = RB'($urandom_range(0, 7));
            result_w    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_bypass_unit.md
OPERAND_BYPASS_UNIT -- requirements
Module: operand_bypass_unit

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32: operand/result width.
REQ-002 SHALL have parameter REG_BITS, default 5: register-number width.
REQ-003 SHALL have parameter NUM_SRC, default 2: source operands per instruction; legal range 1..4.
REQ-004 SHALL have parameter CNT_BITS, default 16: stall-counter width.
REQ-005 SHALL have the following ports:
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- d_valid  in  1  decode-stage instruction present.
- d_src_reg  in  NUM_SRC*REG_BITS  source register numbers; operand i at bits [i*REG_BITS +: REG_BITS].
- d_src_data  in  NUM_SRC*DATA_BITS  register-file read data, same packing.
- d_ready  out  1  unit accepts the decode instruction this cycle.
- e_hold  in  1  execute stage cannot advance.
- flush  in  1  kill the execute-stage slot.
- e_is_load, e_reg_write  in  1 each  execute-stage instruction type.
- e_dst_reg  in  REG_BITS  execute-stage destination.
- m_reg_write  in  1; m_dst_reg  in  REG_BITS; alu_out_m  in  DATA_BITS  memory-stage producer.
- w_reg_write  in  1; w_dst_reg  in  REG_BITS; result_w  in  DATA_BITS  writeback-stage producer.
- e_valid  out  1  execute slot holds a live instruction.
- e_fwd_sel  out  NUM_SRC*2  per-operand select: 00 captured, 01 result_w, 10 alu_out_m.
- src_e  out  NUM_SRC*DATA_BITS  forwarded execute operands.
- load_use_stall  out  1  load-use hazard this cycle.
- stall_cycles  out  CNT_BITS  saturating count of load_use_stall cycles.

Function
REQ-006 SHALL hold per operand a captured-value register cap[i] and a source-register register e_src[i].
REQ-007 SHALL compute, combinationally for each i while e_valid=1: sel 10 if m_reg_write and m_dst_reg==e_src[i] and e_src[i]!=0; else 01 if the same test passes with the w_* inputs; else 00.
REQ-008 SHALL drive src_e[i] from alu_out_m, result_w or cap[i] per sel; with e_valid=0, sel SHALL be 00 and src_e SHALL equal cap.
REQ-009 SHALL assert load_use_stall when d_valid, e_valid, e_is_load, e_reg_write, e_dst_reg!=0, and any d_src_reg[i]==e_dst_reg.
REQ-010 SHALL drive d_ready = !load_use_stall && !(e_valid && e_hold).
REQ-011 SHALL, on accept (d_valid && d_ready && !flush), set e_valid=1 and load e_src[i]; cap[i] SHALL load result_w when w_reg_write and w_dst_reg==d_src_reg[i]!=0, else d_src_data[i].
REQ-012 SHALL, when e_valid && e_hold && !flush, refresh every cap[i] with the current src_e[i] at each edge, so a producer retiring during a hold is not lost.
REQ-013 SHALL, when not holding and not accepting, clear e_valid (bubble); a load-use stall thus inserts exactly one bubble.
REQ-014 SHALL give flush priority over hold and accept: e_valid=0 next cycle and caps unchanged.
REQ-015 SHALL, when e_hold=1 and e_valid=0, treat the slot as empty: d_ready follows REQ-010 and accept is allowed.
REQ-016 SHALL increment stall_cycles on each edge with load_use_stall=1, saturating at all-ones.
REQ-017 SHALL never forward from register 0 at any stage.

Reset
REQ-018 SHALL, while rst_n=0, force e_valid=0, all cap and e_src registers to 0, and stall_cycles to 0, independent of clk.
REQ-019 SHALL, on reset mid-hold or mid-stall, drop the in-flight instruction; first accept allowed on the first edge after release.

Verification
REQ-020 Accept r1=0x11, r2=0x22; next cycle m writes r1 with 0xAA -> sel0=10, src_e0=0xAA, src_e1=0x22.
REQ-021 M and W both write r3 (0x5, 0x6) with operand r3 -> src_e=0x5 (M priority); same test on r0 -> cap value, sel=00.
REQ-022 E load to r4, decode reads r4 -> load_use_stall=1 for one cycle, d_ready=0, bubble, stall_cycles=1; re-accept forwards the load via W.
REQ-023 Hold 3 cycles with M writing r7=0x77 moving to W then retiring -> src_e stays 0x77 throughout, sel 00 after retire.
REQ-024 flush and d_valid same cycle -> e_valid=0; rst_n low mid-hold -> e_valid=0, stall_cycles=0 immediately.
REQ-025 CNT_BITS=2, 5 stall cycles -> stall_cycles saturates at 3.
